// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage: the entry handed
// to decode, the fetch FSM state encoding and the reset PC.
package fetch_unit_pkg;

    typedef logic [63:0] u64;
    typedef logic [31:0] u32;

    typedef struct packed {
        u64   pc;
        u32   instr;
        logic exc;
    } fetch_entry_t;

    localparam u32 NOP_INSTR        = 32'h0000_0013;
    localparam u64 PC_RESET_DEFAULT = 64'h0000_0000_8000_0000;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DROP
    } fetch_state_t;

    // Sequential fetch address; wraps modulo 2^64 with no exception.
    function automatic u64 pc_next(input u64 pc);
        return pc + 64'd4;
    endfunction

    function automatic logic pc_aligned(input u64 pc);
        return pc[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// Small FIFO of fetched entries sitting between the fetch FSM and decode.
// The head is presented straight from the storage registers.
module fetch_skid_buf
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         enq,
    input  fetch_entry_t enq_entry,
    input  logic         deq,
    output logic         head_valid,
    output fetch_entry_t head_entry,
    output logic [1:0]   count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             do_enq, do_deq;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // A flush in the same cycle wins over both enqueue and dequeue.
        do_enq   = enq && !flush;
        do_deq   = deq && (count_q != 2'd0) && !flush;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = 2'd0;
        end else begin
            if (do_enq) begin
                mem_d[wr_ptr_q] = enq_entry;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_deq) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({do_enq, do_deq})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_valid = (count_q != 2'd0);
    assign head_entry = mem_q[rd_ptr_q];
    assign count      = count_q;

    // Issue gating upstream must never let an entry arrive with no room for it.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(enq && !flush && (count_q == 2'(DEPTH)) && !(deq && head_valid)));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: sequential PC generation, one-outstanding instruction
// bus requests, redirect handling with stale-response discard, skid queue to decode.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [63:0] PC_RESET  = PC_RESET_DEFAULT,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ibus_valid,
    output logic [63:0] ibus_addr,
    input  logic        ibus_addr_ok,
    input  logic        ibus_data_ok,
    input  logic [31:0] ibus_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [63:0] dec_pc,
    output logic [31:0] dec_instr,
    output logic        dec_exc
);

    fetch_state_t state_q, state_d;
    logic [63:0]  pc_q, pc_d;
    logic [63:0]  addr_q, addr_d;
    logic         stale_q, stale_d;
    logic         halt_q, halt_d;

    logic         enq;
    fetch_entry_t enq_entry;
    fetch_entry_t head_entry;
    logic         head_valid;
    logic [1:0]   buf_count;
    logic         in_flight;
    logic [2:0]   occupancy;
    logic         has_space;

    // A live (non-stale) request will consume a queue slot when it returns.
    assign in_flight = ((state_q == REQ) || (state_q == WAIT)) && !stale_q;
    assign occupancy = {1'b0, buf_count} + {2'b00, in_flight};
    assign has_space = occupancy < 3'(BUF_DEPTH);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        addr_d    = addr_q;
        stale_d   = stale_q;
        halt_d    = halt_q;
        enq       = 1'b0;
        enq_entry = '{pc: pc_q, instr: ibus_data, exc: 1'b0};

        if (redirect_valid) begin
            pc_d   = redirect_pc;
            halt_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (!redirect_valid && !halt_q && has_space) begin
                    if (!pc_aligned(pc_q)) begin
                        // Misaligned target: hand decode a faulting NOP and park.
                        enq       = 1'b1;
                        enq_entry = '{pc: pc_q, instr: NOP_INSTR, exc: 1'b1};
                        halt_d    = 1'b1;
                    end else begin
                        state_d = REQ;
                        addr_d  = pc_q;
                    end
                end
            end
            REQ: begin
                if (ibus_addr_ok) begin
                    stale_d = 1'b0;
                    if (ibus_data_ok) begin
                        state_d = IDLE;
                        if (!redirect_valid && !stale_q) begin
                            enq  = 1'b1;
                            pc_d = pc_next(pc_q);
                        end
                    end else begin
                        state_d = (redirect_valid || stale_q) ? DROP : WAIT;
                    end
                end else if (redirect_valid) begin
                    // Address must stay put until accepted; the reply gets dropped later.
                    stale_d = 1'b1;
                end
            end
            WAIT: begin
                if (ibus_data_ok) begin
                    state_d = IDLE;
                    if (!redirect_valid) begin
                        enq  = 1'b1;
                        pc_d = pc_next(pc_q);
                    end
                end else if (redirect_valid) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (ibus_data_ok) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pc_q    <= PC_RESET;
            addr_q  <= '0;
            stale_q <= 1'b0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            stale_q <= stale_d;
            halt_q  <= halt_d;
        end
    end

    fetch_skid_buf #(
        .DEPTH (BUF_DEPTH)
    ) u_skid (
        .clk        (clk),
        .rst_n      (reset),
        .flush      (redirect_valid),
        .enq        (enq),
        .enq_entry  (enq_entry),
        .deq        (dec_ready),
        .head_valid (head_valid),
        .head_entry (head_entry),
        .count      (buf_count)
    );

    assign ibus_valid = (state_q == REQ);
    assign ibus_addr  = addr_q;
    assign dec_valid  = head_valid;
    assign dec_pc     = head_entry.pc;
    assign dec_instr  = head_entry.instr;
    assign dec_exc    = head_entry.exc;

    a_addr_aligned: assert property (@(posedge clk) disable iff (!reset)
        ibus_valid |-> (ibus_addr[1:0] == 2'b00));

    a_addr_held: assert property (@(posedge clk) disable iff (!reset)
        (ibus_valid && !ibus_addr_ok) |=> (ibus_valid && $stable(ibus_addr)));

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a behavioural instruction bus, a scoreboard
// of expected decode entries and expected request addresses, and redirect scenarios.
module tb_fetch_unit;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        exc;
    } ent_t;

    typedef struct {
        int          phase;
        int          acc_delay;
        int          data_delay;
        logic [63:0] trig_addr;
        logic [63:0] rpc;
        int          exp_gap;
    } vec_t;

    localparam int PH_WAIT = 0;
    localparam int PH_SAME = 1;
    localparam int PH_REQ  = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ibus_valid;
    logic [63:0] ibus_addr;
    logic        ibus_addr_ok = 1'b0;
    logic        ibus_data_ok = 1'b0;
    logic [31:0] ibus_data = '0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        dec_valid;
    logic        dec_ready = 1'b0;
    logic [63:0] dec_pc;
    logic [31:0] dec_instr;
    logic        dec_exc;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .ibus_valid     (ibus_valid),
        .ibus_addr      (ibus_addr),
        .ibus_addr_ok   (ibus_addr_ok),
        .ibus_data_ok   (ibus_data_ok),
        .ibus_data      (ibus_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_pc         (dec_pc),
        .dec_instr      (dec_instr),
        .dec_exc        (dec_exc)
    );

    int          n_checks = 0;
    int          n_fail = 0;
    ent_t        exp_q[$];
    logic [63:0] exp_addr_q[$];

    int          acc_delay = 0;
    int          data_delay = 2;
    int          acc_wait = 0;
    int          pend_cnt = 0;
    logic        pend_active = 1'b0;
    logic        pend_live = 1'b0;
    logic        req_stale = 1'b0;
    logic [63:0] pend_addr = '0;
    logic        prev_req_open = 1'b0;
    logic [63:0] prev_addr = '0;
    int          n_acc = 0;
    int          n_dec = 0;
    logic [63:0] last_acc_addr = '0;
    logic [63:0] watch_pc = '0;
    logic        saw_watch = 1'b0;

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return {8'hA5, a[23:0]};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        exp_addr_q.delete();
        pend_active   = 1'b0;
        pend_live     = 1'b0;
        req_stale     = 1'b0;
        prev_req_open = 1'b0;
        acc_wait      = acc_delay;
        n_acc         = 0;
        n_dec         = 0;
        saw_watch     = 1'b0;
    endtask

    // One clock: score the decode handshake, apply redirect, play the bus, advance.
    task automatic cycle();
        ent_t e;
        if (prev_req_open) begin
            check("addr_held", 128'({ibus_valid, ibus_addr}), 128'({1'b1, prev_addr}));
        end
        if (dec_valid && dec_ready && !redirect_valid) begin
            n_dec++;
            if (dec_pc == watch_pc) saw_watch = 1'b1;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL dec_unexpected: got pc %0h instr %0h exc %0b, required no entry",
                         dec_pc, dec_instr, dec_exc);
            end else begin
                e = exp_q.pop_front();
                n_checks--;
                check("dec_entry", 128'({dec_pc, dec_instr, dec_exc}), 128'({e.pc, e.instr, e.exc}));
                $display("dec pc=%0h instr=%0h exc=%0b", dec_pc, dec_instr, dec_exc);
            end
        end
        if (redirect_valid) begin
            exp_q.delete();
            if (pend_active) pend_live = 1'b0;
            if (ibus_valid && !pend_active) req_stale = 1'b1;
            if (redirect_pc[1:0] != 2'b00) exp_q.push_back('{redirect_pc, 32'h0000_0013, 1'b1});
        end
        ibus_addr_ok = 1'b0;
        ibus_data_ok = 1'b0;
        ibus_data    = '0;
        if (pend_active) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                ibus_data_ok = 1'b1;
                ibus_data    = instr_of(pend_addr);
                pend_active  = 1'b0;
                if (pend_live) exp_q.push_back('{pend_addr, instr_of(pend_addr), 1'b0});
            end
        end else if (ibus_valid) begin
            if (acc_wait > 0) begin
                acc_wait--;
            end else begin
                ibus_addr_ok  = 1'b1;
                acc_wait      = acc_delay;
                n_acc++;
                last_acc_addr = ibus_addr;
                $display("accept addr=%0h stale=%0b", ibus_addr, req_stale);
                if (!req_stale && exp_addr_q.size() > 0) begin
                    check("ibus_addr", 128'(ibus_addr), 128'(exp_addr_q.pop_front()));
                end
                if (data_delay == 0) begin
                    ibus_data_ok = 1'b1;
                    ibus_data    = instr_of(ibus_addr);
                    if (!req_stale) exp_q.push_back('{ibus_addr, instr_of(ibus_addr), 1'b0});
                end else begin
                    pend_active = 1'b1;
                    pend_live   = !req_stale;
                    pend_cnt    = data_delay;
                    pend_addr   = ibus_addr;
                end
                req_stale = 1'b0;
            end
        end
        prev_req_open = ibus_valid && !ibus_addr_ok;
        prev_addr     = ibus_addr;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset          = 1'b0;
        redirect_valid = 1'b0;
        dec_ready      = 1'b0;
        ibus_addr_ok   = 1'b0;
        ibus_data_ok   = 1'b0;
        ibus_data      = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check("rst_ibus", 128'({ibus_valid, ibus_addr}), 128'(0));
        check("rst_dec", 128'({dec_valid, dec_pc, dec_instr, dec_exc}), 128'(0));
        reset = 1'b1;
    endtask

    task automatic fire_redirect(input logic [63:0] rpc);
        redirect_valid = 1'b1;
        redirect_pc    = rpc;
        $display("redirect pc=%0h", rpc);
        cycle();
    endtask

    initial begin
        vec_t vecs[3];
        logic fired;
        int   gap;
        int   vcount;

        vecs[0] = '{PH_WAIT, 0, 2, 64'h8000_0004, 64'h8000_1000, 3};
        vecs[1] = '{PH_SAME, 0, 0, 64'h8000_0004, 64'h8000_2000, 2};
        vecs[2] = '{PH_REQ,  1, 2, 64'h8000_0004, 64'h8000_3000, 5};

        // Straight-line fetch with full decode throughput.
        acc_delay = 0;
        data_delay = 2;
        do_reset();
        dec_ready = 1'b1;
        exp_addr_q = '{64'h8000_0000, 64'h8000_0004, 64'h8000_0008};
        for (int i = 0; i < 60 && n_dec < 3; i++) cycle();
        check("basic_dec_count", 128'(n_dec >= 3), 128'(1));
        check("basic_addr_count", 128'(exp_addr_q.size()), 128'(0));

        // Decode stalled: queue fills to two and issue stops, then drains in order.
        do_reset();
        exp_addr_q = '{64'h8000_0000, 64'h8000_0004};
        repeat (10) cycle();
        check("stall_accepts", 128'(n_acc), 128'(2));
        check("stall_ibus_idle", 128'(ibus_valid), 128'(0));
        check("stall_head", 128'({dec_valid, dec_pc, dec_instr, dec_exc}),
              128'({1'b1, 64'h8000_0000, instr_of(64'h8000_0000), 1'b0}));
        exp_addr_q.push_back(64'h8000_0008);
        dec_ready = 1'b1;
        for (int i = 0; i < 40 && n_dec < 3; i++) cycle();
        check("stall_drain", 128'(n_dec >= 3), 128'(1));
        check("stall_resume", 128'(last_acc_addr), 128'(64'h8000_0008));

        // Redirects landing in WAIT, with addr_ok&data_ok, and on an unaccepted REQ.
        for (int v = 0; v < 3; v++) begin
            acc_delay  = vecs[v].acc_delay;
            data_delay = vecs[v].data_delay;
            do_reset();
            dec_ready = 1'b1;
            fired = 1'b0;
            for (int i = 0; i < 80 && !fired; i++) begin
                case (vecs[v].phase)
                    PH_WAIT: fired = pend_active && pend_cnt > 1 && pend_addr == vecs[v].trig_addr;
                    PH_SAME: fired = ibus_valid && !pend_active && acc_wait == 0 &&
                                     ibus_addr == vecs[v].trig_addr;
                    default: fired = ibus_valid && !pend_active && acc_wait > 0 &&
                                     ibus_addr == vecs[v].trig_addr;
                endcase
                if (!fired) cycle();
            end
            check("vec_fired", 128'(fired), 128'(1));
            exp_addr_q.delete();
            exp_addr_q.push_back(vecs[v].rpc);
            watch_pc  = vecs[v].rpc;
            saw_watch = 1'b0;
            fire_redirect(vecs[v].rpc);
            gap = 1;
            while (!(ibus_valid && ibus_addr == vecs[v].rpc) && gap < 50) begin
                cycle();
                gap++;
            end
            check("vec_gap", 128'(gap), 128'(vecs[v].exp_gap));
            for (int i = 0; i < 40 && !saw_watch; i++) cycle();
            check("vec_rpc_decoded", 128'(saw_watch), 128'(1));
        end

        // Misaligned redirect: one faulting NOP, then silence until the next redirect.
        acc_delay  = 0;
        data_delay = 2;
        do_reset();
        repeat (10) cycle();
        fire_redirect(64'h8000_0002);
        dec_ready = 1'b1;
        vcount = 0;
        repeat (12) begin
            cycle();
            if (ibus_valid) vcount++;
        end
        check("mis_no_fetch", 128'(vcount), 128'(0));
        check("mis_dec_count", 128'(n_dec), 128'(1));
        check("mis_sb_empty", 128'(exp_q.size()), 128'(0));
        exp_addr_q = '{64'h8000_0100};
        watch_pc  = 64'h8000_0100;
        saw_watch = 1'b0;
        fire_redirect(64'h8000_0100);
        for (int i = 0; i < 40 && !saw_watch; i++) cycle();
        check("mis_recover", 128'(saw_watch), 128'(1));

        // Reset dropped while the second request is outstanding.
        do_reset();
        for (int i = 0; i < 30 && !(pend_active && pend_addr == 64'h8000_0004); i++) cycle();
        check("rst_mid_in_wait", 128'({pend_active, pend_addr}), 128'({1'b1, 64'h8000_0004}));
        reset = 1'b0;
        #1;
        check("rst_mid_ibus", 128'({ibus_valid, ibus_addr}), 128'(0));
        check("rst_mid_dec", 128'({dec_valid, dec_pc, dec_instr, dec_exc}), 128'(0));
        model_clear();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        dec_ready = 1'b1;
        exp_addr_q = '{64'h8000_0000};
        for (int i = 0; i < 20 && n_acc < 1; i++) cycle();
        check("rst_mid_first_addr", 128'({n_acc == 1, last_acc_addr}), 128'({1'b1, 64'h8000_0000}));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of test, required completion within 1 ms");
        $fatal(1, "watchdog expired");
    end

endmodule
